// File: rtl/ibex_pmp_csr_pkg.sv
// Shared PMP configuration types between the PMP CSR block, the PMP checker and testbenches.
package ibex_pmp_csr_pkg;

  typedef struct packed {
    logic       lock;
    logic [1:0] mode;
    logic       exec;
    logic       write;
    logic       read;
  } pmp_cfg_t;

  typedef struct packed {
    logic rlb;
    logic mmwp;
    logic mml;
  } pmp_mseccfg_t;

  localparam logic [1:0] PMP_MODE_OFF   = 2'b00;
  localparam logic [1:0] PMP_MODE_TOR   = 2'b01;
  localparam logic [1:0] PMP_MODE_NA4   = 2'b10;
  localparam logic [1:0] PMP_MODE_NAPOT = 2'b11;

endpackage

// File: rtl/ibex_pmp_csr.sv
// PMP CSR storage (pmpcfg0-3, pmpaddr0-15, mseccfg) enforcing WARL, lock, RLB and MML write rules.
// Define PMP_CSR_SMEPMP_EN to implement mseccfg (Smepmp); otherwise 0x747 is a read-zero, write-ignore hole.
module ibex_pmp_csr
  import ibex_pmp_csr_pkg::*;
#(
  parameter int PMPGranularity = 0,
  parameter int PMPNumRegions  = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         csr_req_i,
  input  logic         csr_we_i,
  input  logic [11:0]  csr_addr_i,
  input  logic [31:0]  csr_wdata_i,
  output logic         csr_rvalid_o,
  output logic [31:0]  csr_rdata_o,
  output logic         csr_err_o,
  output pmp_cfg_t     csr_pmp_cfg_o     [PMPNumRegions],
  output logic [33:0]  csr_pmp_addr_o    [PMPNumRegions],
  output pmp_mseccfg_t csr_pmp_mseccfg_o,
  output logic         pmp_upd_o
);

  pmp_cfg_t    cfg_q  [PMPNumRegions];
  pmp_cfg_t    cfg_d  [PMPNumRegions];
  logic [31:0] addr_q [PMPNumRegions];
  logic [31:0] addr_d [PMPNumRegions];

  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic        upd_q, upd_d;
  logic [31:0] rdata_q, rdata_d;

  logic rlb, mml;
  logic sel_cfg, sel_addr, sel_msec, wr;
  logic [PMPNumRegions-1:0] locked;
  logic [PMPNumRegions-1:0] tor_locked_next;

  assign sel_cfg  = (csr_addr_i[11:2] == 10'h0E8);
  assign sel_addr = (csr_addr_i[11:4] == 8'h3B);
  assign sel_msec = (csr_addr_i == 12'h747);
  assign wr       = csr_req_i & csr_we_i;

  function automatic pmp_cfg_t cfg_legalize(input logic [7:0] b, input logic mml_en);
    pmp_cfg_t c;
    c.lock  = b[7];
    c.mode  = b[4:3];
    c.exec  = b[2];
    c.write = b[1];
    c.read  = b[0];
    // Write-only is reserved outside MML; clear the permission bits but keep L and A.
    if (!mml_en && !b[0] && b[1]) begin
      c.exec  = 1'b0;
      c.write = 1'b0;
      c.read  = 1'b0;
    end
    if (PMPGranularity >= 1 && c.mode == PMP_MODE_NA4) c.mode = PMP_MODE_OFF;
    return c;
  endfunction

  function automatic logic mml_blocked(input logic [7:0] b, input logic mml_en, input logic rlb_en);
    return mml_en & ~rlb_en & b[7] & (b[2] | (~b[0] & b[1]));
  endfunction

  function automatic logic [7:0] cfg_rd(input pmp_cfg_t c);
    return {c.lock, 2'b00, c.mode, c.exec, c.write, c.read};
  endfunction

  function automatic logic [31:0] addr_rd(input logic [31:0] a, input logic [1:0] mode);
    logic [31:0] r;
    r = a;
    for (int b = 0; b < 32; b++) begin
      if (PMPGranularity >= 2 && mode == PMP_MODE_NAPOT && b <= PMPGranularity - 2) r[b] = 1'b1;
      if (PMPGranularity >= 1 && !mode[1] && b < PMPGranularity) r[b] = 1'b0;
    end
    return r;
  endfunction

`ifdef PMP_CSR_SMEPMP_EN
  pmp_mseccfg_t mseccfg_q, mseccfg_d;
  logic [PMPNumRegions-1:0] lock_bits;

  assign rlb = mseccfg_q.rlb;
  assign mml = mseccfg_q.mml;
  assign csr_pmp_mseccfg_o = mseccfg_q;

  // RLB may only change while it is already set or nothing is locked, judged on pre-write state.
  always_comb begin
    lock_bits = '0;
    for (int i = 0; i < PMPNumRegions; i++) lock_bits[i] = cfg_q[i].lock;
    mseccfg_d = mseccfg_q;
    if (wr && sel_msec) begin
      mseccfg_d.mml  = mseccfg_q.mml | csr_wdata_i[0];
      mseccfg_d.mmwp = mseccfg_q.mmwp | csr_wdata_i[1];
      if (mseccfg_q.rlb || !(|lock_bits)) mseccfg_d.rlb = csr_wdata_i[2];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) mseccfg_q <= '0;
    else       mseccfg_q <= mseccfg_d;
  end
`else
  assign rlb = 1'b0;
  assign mml = 1'b0;
  assign csr_pmp_mseccfg_o = '0;
`endif

  always_comb begin
    locked          = '0;
    tor_locked_next = '0;
    for (int i = 0; i < PMPNumRegions; i++) locked[i] = cfg_q[i].lock & ~rlb;
    for (int i = 1; i < PMPNumRegions; i++) begin
      tor_locked_next[i-1] = locked[i] & (cfg_q[i].mode == PMP_MODE_TOR);
    end
  end

  always_comb begin
    cfg_d  = cfg_q;
    addr_d = addr_q;
    for (int i = 0; i < PMPNumRegions; i++) begin
      if (wr && sel_cfg && csr_addr_i[1:0] == 2'(i / 4) && !locked[i] &&
          !mml_blocked(csr_wdata_i[8*(i%4) +: 8], mml, rlb)) begin
        cfg_d[i] = cfg_legalize(csr_wdata_i[8*(i%4) +: 8], mml);
      end
      if (wr && sel_addr && csr_addr_i[3:0] == 4'(i) && !locked[i] && !tor_locked_next[i]) begin
        addr_d[i] = csr_wdata_i;
      end
    end
  end

  always_comb begin
    rdata_d  = '0;
    rvalid_d = csr_req_i;
    err_d    = csr_req_i & ~(sel_cfg | sel_addr | sel_msec);
    if (csr_req_i && !csr_we_i) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        if (sel_cfg && csr_addr_i[1:0] == 2'(i / 4)) rdata_d[8*(i%4) +: 8] = cfg_rd(cfg_q[i]);
        if (sel_addr && csr_addr_i[3:0] == 4'(i))    rdata_d = addr_rd(addr_q[i], cfg_q[i].mode);
      end
`ifdef PMP_CSR_SMEPMP_EN
      if (sel_msec) rdata_d = {29'd0, mseccfg_q};
`endif
    end
  end

  // Only a real change of stored state flushes the core's prefetch buffer.
  always_comb begin
    upd_d = 1'b0;
    for (int i = 0; i < PMPNumRegions; i++) begin
      if (cfg_d[i] != cfg_q[i] || addr_d[i] != addr_q[i]) upd_d = 1'b1;
    end
`ifdef PMP_CSR_SMEPMP_EN
    if (mseccfg_d != mseccfg_q) upd_d = 1'b1;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < PMPNumRegions; i++) begin
        cfg_q[i]  <= '0;
        addr_q[i] <= '0;
      end
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      upd_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      cfg_q    <= cfg_d;
      addr_q   <= addr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    for (int i = 0; i < PMPNumRegions; i++) begin
      csr_pmp_cfg_o[i]  = cfg_q[i];
      csr_pmp_addr_o[i] = {addr_q[i], 2'b00};
    end
  end

  assign csr_rvalid_o = rvalid_q;
  assign csr_rdata_o  = rdata_q;
  assign csr_err_o    = err_q;
  assign pmp_upd_o    = upd_q;

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Testbench for ibex_pmp_csr: two instances (G=0/4 entries, G=2/6 entries) driven with shared
// directed and random CSR traffic, checked against a byte-level reference model.
module tb_ibex_pmp_csr;
  import ibex_pmp_csr_pkg::*;

`ifdef PMP_CSR_SMEPMP_EN
  localparam bit SMEP = 1'b1;
`else
  localparam bit SMEP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [11:0] addr;
  logic [31:0] wdata;

  logic         rv0, err0, upd0;
  logic [31:0]  rd0;
  pmp_cfg_t     cfg0 [4];
  logic [33:0]  pa0  [4];
  pmp_mseccfg_t ms0;

  logic         rv2, err2, upd2;
  logic [31:0]  rd2;
  pmp_cfg_t     cfg2 [6];
  logic [33:0]  pa2  [6];
  pmp_mseccfg_t ms2;

  always #5 clk = ~clk;

  ibex_pmp_csr #(.PMPGranularity(0), .PMPNumRegions(4)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .csr_req_i(req), .csr_we_i(we), .csr_addr_i(addr),
    .csr_wdata_i(wdata), .csr_rvalid_o(rv0), .csr_rdata_o(rd0), .csr_err_o(err0),
    .csr_pmp_cfg_o(cfg0), .csr_pmp_addr_o(pa0), .csr_pmp_mseccfg_o(ms0), .pmp_upd_o(upd0)
  );

  ibex_pmp_csr #(.PMPGranularity(2), .PMPNumRegions(6)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .csr_req_i(req), .csr_we_i(we), .csr_addr_i(addr),
    .csr_wdata_i(wdata), .csr_rvalid_o(rv2), .csr_rdata_o(rd2), .csr_err_o(err2),
    .csr_pmp_cfg_o(cfg2), .csr_pmp_addr_o(pa2), .csr_pmp_mseccfg_o(ms2), .pmp_upd_o(upd2)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: per instance, cfg bytes as architecturally visible, raw address words, mseccfg bits {rlb,mmwp,mml}.
  logic [7:0]  m_cfg  [2][16];
  logic [31:0] m_addr [2][16];
  logic [2:0]  m_ms   [2];

  function automatic int gran(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic int nreg(input int d);
    return (d == 0) ? 4 : 6;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ms[d] = 3'b000;
      for (int i = 0; i < 16; i++) begin
        m_cfg[d][i]  = 8'h00;
        m_addr[d][i] = 32'h0;
      end
    end
  endtask

  function automatic logic is_locked(input int d, input int i, input logic rlb_v);
    return m_cfg[d][i][7] && !rlb_v;
  endfunction

  task automatic model_op(input int d, input logic w, input logic [11:0] a, input logic [31:0] wd,
                          output logic [31:0] ed, output logic ee, output logic eu);
    logic [7:0]  pc [16];
    logic [31:0] pa [16];
    logic [2:0]  pm;
    logic        rlb_v, mml_v, any_l;
    logic [7:0]  b, nb;
    logic [31:0] v;
    int g, nr, n, idx;
    g = gran(d);
    nr = nreg(d);
    pm = m_ms[d];
    for (int i = 0; i < 16; i++) begin
      pc[i] = m_cfg[d][i];
      pa[i] = m_addr[d][i];
    end
    rlb_v = SMEP && m_ms[d][2];
    mml_v = SMEP && m_ms[d][0];
    ed = 32'h0;
    ee = 1'b0;
    if (a >= 12'h3A0 && a <= 12'h3A3) begin
      n = int'(a) - 'h3A0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * n + j;
        if (idx < nr) begin
          if (!w) ed[8*j +: 8] = m_cfg[d][idx];
          else if (!is_locked(d, idx, rlb_v)) begin
            b = wd[8*j +: 8];
            if (!(mml_v && !rlb_v && b[7] && (b[2] || (!b[0] && b[1])))) begin
              nb = b & 8'h9F;
              if (!mml_v && !b[0] && b[1]) nb = nb & 8'h98;
              if (g >= 1 && nb[4:3] == 2'b10) nb = nb & 8'hE7;
              m_cfg[d][idx] = nb;
            end
          end
        end
      end
    end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
      n = int'(a) - 'h3B0;
      if (n < nr) begin
        if (!w) begin
          v = m_addr[d][n];
          if (g >= 2 && m_cfg[d][n][4:3] == 2'b11) v = v | ((32'd1 << (g - 1)) - 32'd1);
          if (g >= 1 && m_cfg[d][n][4:3] < 2'b10) v = v & ~((32'd1 << g) - 32'd1);
          ed = v;
        end else if (!is_locked(d, n, rlb_v)) begin
          if (n + 1 < nr) begin
            if (!(is_locked(d, n + 1, rlb_v) && m_cfg[d][n+1][4:3] == 2'b01)) m_addr[d][n] = wd;
          end else begin
            m_addr[d][n] = wd;
          end
        end
      end
    end else if (a == 12'h747) begin
      if (SMEP) begin
        if (!w) ed = {29'd0, m_ms[d]};
        else begin
          any_l = 1'b0;
          for (int i = 0; i < nr; i++) if (m_cfg[d][i][7]) any_l = 1'b1;
          m_ms[d][0] = m_ms[d][0] | wd[0];
          m_ms[d][1] = m_ms[d][1] | wd[1];
          if (pm[2] || !any_l) m_ms[d][2] = wd[2];
        end
      end
    end else begin
      ee = 1'b1;
    end
    eu = (pm != m_ms[d]);
    for (int i = 0; i < 16; i++) begin
      if (pc[i] != m_cfg[d][i] || pa[i] != m_addr[d][i]) eu = 1'b1;
    end
  endtask

  task automatic check_state();
    logic [63:0] o, e;
    o = '0;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      o[6*i +: 6] = cfg0[i];
      e[6*i +: 6] = {m_cfg[0][i][7], m_cfg[0][i][4:0]};
      check($sformatf("addr_out0[%0d]", i), 64'(pa0[i]), 64'({m_addr[0][i], 2'b00}));
    end
    check("cfg_out0", o, e);
    o = '0;
    e = '0;
    for (int i = 0; i < 6; i++) begin
      o[6*i +: 6] = cfg2[i];
      e[6*i +: 6] = {m_cfg[1][i][7], m_cfg[1][i][4:0]};
      check($sformatf("addr_out2[%0d]", i), 64'(pa2[i]), 64'({m_addr[1][i], 2'b00}));
    end
    check("cfg_out2", o, e);
    check("msec_out0", 64'(ms0), SMEP ? 64'(m_ms[0]) : 64'd0);
    check("msec_out2", 64'(ms2), SMEP ? 64'(m_ms[1]) : 64'd0);
  endtask

  task automatic do_op(input logic w, input logic [11:0] a, input logic [31:0] wd);
    logic [31:0] ed0, ed2;
    logic ee0, eu0, ee2, eu2;
    @(negedge clk);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = wd;
    model_op(0, w, a, wd, ed0, ee0, eu0);
    model_op(1, w, a, wd, ed2, ee2, eu2);
    @(posedge clk);
    #1;
    check($sformatf("rvalid0 @%h", a), 64'(rv0), 64'd1);
    check($sformatf("rdata0 @%h", a), 64'(rd0), 64'(ed0));
    check($sformatf("err0 @%h", a), 64'(err0), 64'(ee0));
    check($sformatf("upd0 @%h", a), 64'(upd0), 64'(eu0));
    check($sformatf("rvalid2 @%h", a), 64'(rv2), 64'd1);
    check($sformatf("rdata2 @%h", a), 64'(rd2), 64'(ed2));
    check($sformatf("err2 @%h", a), 64'(err2), 64'(ee2));
    check($sformatf("upd2 @%h", a), 64'(upd2), 64'(eu2));
    check_state();
  endtask

  task automatic do_idle();
    @(negedge clk);
    req = 1'b0;
    we = 1'b0;
    @(posedge clk);
    #1;
    check("idle_rvalid0", 64'(rv0), 64'd0);
    check("idle_upd0", 64'(upd0), 64'd0);
    check("idle_rvalid2", 64'(rv2), 64'd0);
    check("idle_upd2", 64'(upd2), 64'd0);
  endtask

  task automatic do_reset(input logic with_req);
    @(negedge clk);
    rst = 1'b1;
    req = with_req;
    we = 1'b0;
    addr = 12'h3A0;
    wdata = $urandom;
    @(posedge clk);
    #1;
    model_reset();
    check("rst_rvalid0", 64'(rv0), 64'd0);
    check("rst_rdata0", 64'(rd0), 64'd0);
    check("rst_err0", 64'(err0), 64'd0);
    check("rst_upd0", 64'(upd0), 64'd0);
    check("rst_rvalid2", 64'(rv2), 64'd0);
    check("rst_upd2", 64'(upd2), 64'd0);
    check_state();
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
  endtask

  initial begin
    logic [11:0] ra;
    logic [31:0] rw;
    int sel;
    rst = 1'b1;
    req = 1'b0;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    model_reset();
    do_reset(1'b0);

    do_op(1'b1, 12'h3A0, 32'h0000_1F0F);
    check("plan_cfg_upd", 64'(upd0), 64'd1);
    do_op(1'b0, 12'h3A0, 32'h0);
    check("plan_cfg_rb", 64'(rd0), 64'h0000_1F0F);
    do_op(1'b1, 12'h3A0, 32'h0000_1F8F);
    do_op(1'b1, 12'h3B0, 32'h0000_1234);
    do_op(1'b1, 12'h3A0, 32'h0000_0700);
    do_op(1'b1, 12'h3A0, 32'h0000_0700);
    check("plan_repeat_no_upd", 64'(upd0), 64'd0);
    do_op(1'b0, 12'h3A0, 32'h0);
    check("plan_lock_rb", 64'(rd0), 64'h0000_078F);
    do_op(1'b0, 12'h3B0, 32'h0);
    do_idle();

    do_reset(1'b1);
    do_op(1'b1, 12'h3A0, 32'h0000_8900);
    do_op(1'b1, 12'h3B0, 32'h0000_0100);
    do_op(1'b0, 12'h3B0, 32'h0);
    check("plan_tor_lock_rb", 64'(rd2), 64'd0);

    do_reset(1'b0);
    do_op(1'b1, 12'h747, 32'h7);
    do_op(1'b0, 12'h747, 32'h0);
    check("plan_msec_7", 64'(rd0), SMEP ? 64'h7 : 64'h0);
    do_op(1'b1, 12'h747, 32'h0);
    do_op(1'b0, 12'h747, 32'h0);
    check("plan_msec_sticky", 64'(rd0), SMEP ? 64'h3 : 64'h0);
    do_op(1'b1, 12'h3A0, 32'h0000_0080);
    do_op(1'b1, 12'h747, 32'h4);
    do_op(1'b0, 12'h747, 32'h0);
    check("plan_msec_rlb_held", 64'(rd0), SMEP ? 64'h3 : 64'h0);

    do_reset(1'b0);
    do_op(1'b1, 12'h747, 32'h1);
    do_op(1'b1, 12'h3A0, 32'h0000_0384);
    do_op(1'b0, 12'h3A0, 32'h0);
    check("plan_mml_filter", 64'(rd0), SMEP ? 64'h0000_0300 : 64'h0000_0384);
    do_reset(1'b0);
    do_op(1'b1, 12'h3A0, 32'h0000_0002);
    do_op(1'b0, 12'h3A0, 32'h0);
    check("plan_warl_wonly", 64'(rd0), 64'h0);

    do_reset(1'b0);
    do_op(1'b1, 12'h3A0, 32'h0000_0018);
    do_op(1'b0, 12'h3B0, 32'h0);
    check("plan_napot_g2", 64'(rd2), 64'h1);
    do_op(1'b1, 12'h3A0, 32'h0000_0008);
    do_op(1'b1, 12'h3B0, 32'h0000_00FF);
    do_op(1'b0, 12'h3B0, 32'h0);
    check("plan_tor_g2", 64'(rd2), 64'hFC);
    check("plan_tor_g0", 64'(rd0), 64'hFF);
    do_op(1'b1, 12'h3A0, 32'h0000_0010);
    do_op(1'b0, 12'h3C0, 32'h0);
    check("plan_err_3c0", 64'(err0), 64'd1);
    do_op(1'b1, 12'h3A1, 32'h1F1F_1F1F);
    do_op(1'b0, 12'h3A1, 32'h0);
    do_op(1'b1, 12'h3B5, 32'hDEAD_BEEF);
    do_op(1'b1, 12'h3BF, 32'h1234_5678);
    do_op(1'b0, 12'h3B5, 32'h0);

    for (int it = 0; it < 900; it++) begin
      if (it % 45 == 44) do_reset(1'($urandom_range(0, 1)));
      sel = $urandom_range(0, 9);
      rw = $urandom;
      if ($urandom_range(0, 1) == 0) rw = rw & 32'h7F7F_7F7F;
      case (sel)
        0, 1, 2: ra = 12'h3A0 + 12'($urandom_range(0, 3));
        3, 4, 5, 6: ra = 12'h3B0 + 12'($urandom_range(0, 15));
        7: ra = 12'h747;
        8: ra = 12'($urandom_range(0, 4095));
        default: ra = 12'h0;
      endcase
      if (sel == 9) do_idle();
      else do_op(1'($urandom_range(0, 1)), ra, rw);
    end
    do_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
